// File: rtl/trap_ctrl_if.sv
// ---------------------------------------------------------------------------
// trap_ctrl_if
//
// Single read/write port of the machine-mode CSR register file.
//   csr_rdaddr  12  read address (driven by the trap sequencer)
//   csr_rddata  32  read data, registered: valid the cycle after csr_rdaddr;
//                   a read of the address being written returns the write data
//   csr_wren     1  write enable
//   csr_wraddr  12  write address
//   csr_wrdata  32  write data
//
// master : trap sequencer side (drives addresses/write data)
// slave  : CSR register file side (returns read data)
// ---------------------------------------------------------------------------
interface trap_ctrl_if;
  logic [11:0] csr_rdaddr;
  logic [31:0] csr_rddata;
  logic        csr_wren;
  logic [11:0] csr_wraddr;
  logic [31:0] csr_wrdata;

  modport master (
    output csr_rdaddr,
    output csr_wren,
    output csr_wraddr,
    output csr_wrdata,
    input  csr_rddata
  );

  modport slave (
    input  csr_rdaddr,
    input  csr_wren,
    input  csr_wraddr,
    input  csr_wrdata,
    output csr_rddata
  );
endinterface

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Machine-mode trap sequencer. Owns the single CSR file port: takes ecall,
// ebreak and the timer interrupt, executes mret, performs the MEPC/MCAUSE/
// MSTATUS updates one per cycle while stalling the pipeline, then redirects
// the PC. When idle, EX-stage CSR traffic passes straight through.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ex_pc               PC of the instruction in EX
//   ex_valid            EX holds a live instruction
//   ex_ecall/ebreak/mret decoded EX flags (qualified by ex_valid)
//   irq_timer           level timer interrupt request
//   glb_int_en          mstatus.MIE from the CSR file
//   ex_csr_*            pipeline CSR read/write request
//   csr                 CSR file port (master side)
//   hold                stall IF/ID/EX
//   jump_en, jump_addr  one-cycle PC redirect and its target
// ---------------------------------------------------------------------------
module trap_ctrl #(
  parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
  parameter logic [31:0] MCAUSE_EBREAK = 32'd3,
  parameter logic [31:0] MCAUSE_TIMER  = 32'h8000_0007
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ex_pc,
  input  logic              ex_ecall,
  input  logic              ex_ebreak,
  input  logic              ex_mret,
  input  logic              ex_valid,
  input  logic              irq_timer,
  input  logic              glb_int_en,
  input  logic [11:0]       ex_csr_rdaddr,
  input  logic [11:0]       ex_csr_wraddr,
  input  logic              ex_csr_wren,
  input  logic [31:0]       ex_csr_wrdata,
  trap_ctrl_if.master       csr,
  output logic              hold,
  output logic              jump_en,
  output logic [31:0]       jump_addr
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_EPC,
    S_T_CAUSE,
    S_T_STAT,
    S_T_JUMP,
    S_R_EPC,
    S_R_STAT,
    S_R_JUMP
  } state_e;

  state_e      state_q;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic [31:0] mstatus_q;
  logic [31:2] mtvec_q;     // direct mode only: MODE bits are never used
  logic [31:0] mepc_q;

  logic        trap_sel;
  logic        mret_sel;
  logic        accept;
  logic [31:0] cause_d;
  logic [31:0] trap_mstatus;
  logic [31:0] mret_mstatus;

  // Event selection, only meaningful in IDLE. Fixed priority:
  // ecall > ebreak > mret > timer interrupt.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    trap_sel = 1'b0;
    mret_sel = 1'b0;
    cause_d  = '0;
    if (state_q == S_IDLE) begin
      if (ex_valid && ex_ecall) begin
        trap_sel = 1'b1;
        cause_d  = MCAUSE_ECALL;
      end else if (ex_valid && ex_ebreak) begin
        trap_sel = 1'b1;
        cause_d  = MCAUSE_EBREAK;
      end else if (ex_valid && ex_mret) begin
        mret_sel = 1'b1;
      end else if (irq_timer && glb_int_en) begin
        trap_sel = 1'b1;
        cause_d  = MCAUSE_TIMER;
      end
    end
  end

  assign accept = trap_sel | mret_sel;
  assign hold   = accept | (state_q != S_IDLE);

  // Trap entry: MPIE <- MIE, MIE <- 0. mret: MIE <- MPIE, MPIE <- 1.
  assign trap_mstatus = {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0,
                         mstatus_q[2:0]};
  assign mret_mstatus = {mstatus_q[31:8], 1'b1, mstatus_q[6:4], mstatus_q[7],
                         mstatus_q[2:0]};

  // CSR port drive. In IDLE without an accepted event the pipeline owns the
  // port; an accepting cycle suppresses the pipeline write because that
  // instruction is squashed and re-executed after mret.
  always_comb begin
    csr.csr_rdaddr = '0;
    csr.csr_wren   = 1'b0;
    csr.csr_wraddr = '0;
    csr.csr_wrdata = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          csr.csr_rdaddr = CSR_MSTATUS;
        end else begin
          csr.csr_rdaddr = ex_csr_rdaddr;
          csr.csr_wren   = ex_csr_wren;
          csr.csr_wraddr = ex_csr_wraddr;
          csr.csr_wrdata = ex_csr_wrdata;
        end
      end
      S_T_EPC: begin
        csr.csr_wren   = 1'b1;
        csr.csr_wraddr = CSR_MEPC;
        csr.csr_wrdata = epc_q;
        csr.csr_rdaddr = CSR_MTVEC;
      end
      S_T_CAUSE: begin
        csr.csr_wren   = 1'b1;
        csr.csr_wraddr = CSR_MCAUSE;
        csr.csr_wrdata = cause_q;
      end
      S_T_STAT: begin
        csr.csr_wren   = 1'b1;
        csr.csr_wraddr = CSR_MSTATUS;
        csr.csr_wrdata = trap_mstatus;
      end
      S_R_EPC: begin
        csr.csr_rdaddr = CSR_MEPC;
      end
      S_R_STAT: begin
        csr.csr_wren   = 1'b1;
        csr.csr_wraddr = CSR_MSTATUS;
        csr.csr_wrdata = mret_mstatus;
      end
      default: ;
    endcase
  end

  // The redirect is a pure decode of registered state, so it is high for
  // exactly the one JUMP cycle and drops to zero everywhere else.
  assign jump_en   = (state_q == S_T_JUMP) || (state_q == S_R_JUMP);
  assign jump_addr = (state_q == S_T_JUMP) ? {mtvec_q, 2'b00} :
                     (state_q == S_R_JUMP) ? mepc_q : '0;

  // Sequencer. Read data is registered in the CSR file, so each capture
  // happens one state after the corresponding read address was presented.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and ordering between statements cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            epc_q   <= ex_pc;
            cause_q <= cause_d;
            state_q <= trap_sel ? S_T_EPC : S_R_EPC;
          end
        end
        S_T_EPC: begin
          mstatus_q <= csr.csr_rddata;
          state_q   <= S_T_CAUSE;
        end
        S_T_CAUSE: begin
          mtvec_q <= csr.csr_rddata[31:2];
          state_q <= S_T_STAT;
        end
        S_T_STAT: state_q <= S_T_JUMP;
        S_T_JUMP: state_q <= S_IDLE;
        S_R_EPC: begin
          mstatus_q <= csr.csr_rddata;
          state_q   <= S_R_STAT;
        end
        S_R_STAT: begin
          mepc_q  <= csr.csr_rddata;
          state_q <= S_R_JUMP;
        end
        S_R_JUMP: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Drives trap_ctrl against a behavioural CSR register file and checks every
// cycle against a trace-level reference model: on each accepted event the
// model expands the architectural effect (which CSR gets which value, when,
// and where the PC goes) into a queue of expected per-cycle port values.
// Directed scenarios come first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_pc;
  logic        ex_ecall, ex_ebreak, ex_mret, ex_valid, irq_timer;
  logic        glb_int_en;
  logic [11:0] ex_csr_rdaddr, ex_csr_wraddr;
  logic        ex_csr_wren;
  logic [31:0] ex_csr_wrdata;
  logic        hold, jump_en;
  logic [31:0] jump_addr;

  always #5 clk = ~clk;

  trap_ctrl_if csr_bus ();

  trap_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ex_pc         (ex_pc),
    .ex_ecall      (ex_ecall),
    .ex_ebreak     (ex_ebreak),
    .ex_mret       (ex_mret),
    .ex_valid      (ex_valid),
    .irq_timer     (irq_timer),
    .glb_int_en    (glb_int_en),
    .ex_csr_rdaddr (ex_csr_rdaddr),
    .ex_csr_wraddr (ex_csr_wraddr),
    .ex_csr_wren   (ex_csr_wren),
    .ex_csr_wrdata (ex_csr_wrdata),
    .csr           (csr_bus),
    .hold          (hold),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr)
  );

  // Behavioural CSR register file (environment, written by the DUT).
  bit   [31:0] env_mem [0:4095];
  logic [31:0] env_rddata;

  assign csr_bus.csr_rddata = env_rddata;
  assign glb_int_en         = env_mem[A_MSTATUS][3];

  always @(posedge clk) begin
    if (csr_bus.csr_wren && (csr_bus.csr_wraddr == csr_bus.csr_rdaddr))
      env_rddata <= csr_bus.csr_wrdata;
    else
      env_rddata <= env_mem[csr_bus.csr_rdaddr];
    if (csr_bus.csr_wren)
      env_mem[csr_bus.csr_wraddr] <= csr_bus.csr_wrdata;
  end

  // Reference model: architectural CSR state plus expected-cycle queue.
  typedef struct {
    logic        hold;
    logic        wren;
    logic [11:0] wraddr;
    logic [31:0] wrdata;
    logic [11:0] rdaddr;
    logic        jump_en;
    logic [31:0] jump_addr;
  } exp_t;

  bit   [31:0] mdl_csr [0:4095];
  exp_t        exp_q [$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          hold_cnt = 0;
  int          jump_cnt = 0;
  logic [31:0] seen_jump = '0;

  // Staged stimulus, applied just after each rising edge.
  logic        s_rst, s_valid, s_ecall, s_ebreak, s_mret, s_irq, s_wren;
  logic [31:0] s_pc, s_wrdata;
  logic [11:0] s_rdaddr, s_wraddr;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic we, input logic [11:0] wa,
                              input logic [31:0] wd, input logic [11:0] ra,
                              input logic je, input logic [31:0] ja);
    exp_t e;
    e.hold = h; e.wren = we; e.wraddr = wa; e.wrdata = wd;
    e.rdaddr = ra; e.jump_en = je; e.jump_addr = ja;
    return e;
  endfunction

  // Decide what this cycle (and the following ones) must look like.
  task automatic model_issue();
    logic [31:0] ms, ms_new, cause;
    bit          trap, mret;
    if (exp_q.size() != 0) return;
    trap = 0; mret = 0; cause = '0;
    if (s_valid && s_ecall)              begin trap = 1; cause = 32'd11; end
    else if (s_valid && s_ebreak)        begin trap = 1; cause = 32'd3; end
    else if (s_valid && s_mret)          mret = 1;
    else if (s_irq && glb_int_en)        begin trap = 1; cause = 32'h8000_0007; end
    ms = mdl_csr[A_MSTATUS];
    if (trap) begin
      ms_new    = ms;
      ms_new[7] = ms[3];
      ms_new[3] = 1'b0;
      exp_q.push_back(mk(1, 0, '0, '0, A_MSTATUS, 0, '0));
      exp_q.push_back(mk(1, 1, A_MEPC, s_pc, A_MTVEC, 0, '0));
      exp_q.push_back(mk(1, 1, A_MCAUSE, cause, '0, 0, '0));
      exp_q.push_back(mk(1, 1, A_MSTATUS, ms_new, '0, 0, '0));
      exp_q.push_back(mk(1, 0, '0, '0, '0, 1, mdl_csr[A_MTVEC] & 32'hFFFF_FFFC));
    end else if (mret) begin
      ms_new    = ms;
      ms_new[3] = ms[7];
      ms_new[7] = 1'b1;
      exp_q.push_back(mk(1, 0, '0, '0, A_MSTATUS, 0, '0));
      exp_q.push_back(mk(1, 0, '0, '0, A_MEPC, 0, '0));
      exp_q.push_back(mk(1, 1, A_MSTATUS, ms_new, '0, 0, '0));
      exp_q.push_back(mk(1, 0, '0, '0, '0, 1, mdl_csr[A_MEPC]));
    end else begin
      exp_q.push_back(mk(0, s_wren, s_wraddr, s_wrdata, s_rdaddr, 0, '0));
    end
  endtask

  task automatic model_check();
    exp_t e;
    e = exp_q.pop_front();
    check("hold", hold, e.hold);
    check("csr_wren", csr_bus.csr_wren, e.wren);
    check("csr_rdaddr", csr_bus.csr_rdaddr, e.rdaddr);
    check("jump_en", jump_en, e.jump_en);
    if (e.wren) begin
      check("csr_wraddr", csr_bus.csr_wraddr, e.wraddr);
      check("csr_wrdata", csr_bus.csr_wrdata, e.wrdata);
      mdl_csr[e.wraddr] = e.wrdata;
    end
    if (e.jump_en) check("jump_addr", jump_addr, e.jump_addr);
    if (s_rst) exp_q.delete();
    if (hold) hold_cnt++;
    if (jump_en) begin
      jump_cnt++;
      seen_jump = jump_addr;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = s_rst; ex_valid = s_valid; ex_ecall = s_ecall; ex_ebreak = s_ebreak;
    ex_mret = s_mret; irq_timer = s_irq; ex_pc = s_pc;
    ex_csr_rdaddr = s_rdaddr; ex_csr_wraddr = s_wraddr;
    ex_csr_wren = s_wren; ex_csr_wrdata = s_wrdata;
    model_issue();
    @(negedge clk);
    model_check();
  endtask

  task automatic idle();
    s_rst = 0; s_valid = 0; s_ecall = 0; s_ebreak = 0; s_mret = 0; s_irq = 0;
    s_wren = 0; s_pc = '0; s_wrdata = '0; s_rdaddr = '0; s_wraddr = '0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    idle();
    s_valid = 1; s_wren = 1; s_wraddr = a; s_wrdata = d;
    step();
    idle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return A_MSTATUS;
      1: return A_MTVEC;
      2: return A_MSCRATCH;
      3: return A_MEPC;
      4: return A_MCAUSE;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] ms_snap;
    int          jc_snap;

    rst = 1; ex_valid = 0; ex_ecall = 0; ex_ebreak = 0; ex_mret = 0;
    irq_timer = 0; ex_pc = '0; ex_csr_rdaddr = '0; ex_csr_wraddr = '0;
    ex_csr_wren = 0; ex_csr_wrdata = '0;

    // Reset
    idle(); s_rst = 1;
    run(2);
    idle();
    step();
    check("rst_hold", hold, 0);
    check("rst_jump_en", jump_en, 0);
    check("rst_jump_addr", jump_addr, 32'h0);

    // Idle pass-through
    s_wren = 1; s_wraddr = A_MSCRATCH; s_wrdata = 32'hA5A5_0001; s_rdaddr = A_MTVEC;
    step();
    check("pt_wren", csr_bus.csr_wren, 1);
    check("pt_wraddr", csr_bus.csr_wraddr, 32'h340);
    check("pt_wrdata", csr_bus.csr_wrdata, 32'hA5A5_0001);
    check("pt_hold", hold, 0);
    idle();

    // ecall with mtvec=0x203, mstatus=0x8
    csr_write(A_MTVEC, 32'h0000_0203);
    csr_write(A_MSTATUS, 32'h0000_0008);
    hold_cnt = 0;
    s_valid = 1; s_ecall = 1; s_pc = 32'h0000_0100;
    run(5);
    idle();
    step();
    check("ecall_hold_cycles", hold_cnt, 5);
    check("ecall_mepc", env_mem[A_MEPC], 32'h0000_0100);
    check("ecall_mcause", env_mem[A_MCAUSE], 32'd11);
    check("ecall_mstatus", env_mem[A_MSTATUS], 32'h0000_0080);
    check("ecall_jump", seen_jump, 32'h0000_0200);

    // mret back
    s_valid = 1; s_mret = 1;
    run(4);
    idle();
    step();
    check("mret_mstatus", env_mem[A_MSTATUS], 32'h0000_0088);
    check("mret_jump", seen_jump, 32'h0000_0100);

    // Timer interrupt over a csrw in EX
    s_irq = 1; s_valid = 1; s_wren = 1; s_wraddr = A_MSCRATCH; s_wrdata = 32'hDEAD_BEEF;
    s_pc = 32'h0000_0180;
    step();
    check("tmr_wr_suppressed", csr_bus.csr_wren, 0);
    check("tmr_accept_hold", hold, 1);
    run(4);
    idle(); s_irq = 1;
    step();
    check("tmr_no_retrap_hold", hold, 0);
    check("tmr_mcause", env_mem[A_MCAUSE], 32'h8000_0007);
    check("tmr_mscratch_kept", env_mem[A_MSCRATCH], 32'hA5A5_0001);

    // Restore MIE, then ecall together with the timer
    idle(); s_valid = 1; s_mret = 1;
    run(4);
    idle();
    step();
    s_valid = 1; s_ecall = 1; s_irq = 1; s_pc = 32'h0000_0200;
    run(5);
    check("both_mcause", env_mem[A_MCAUSE], 32'd11);
    idle(); s_valid = 1; s_mret = 1; s_irq = 1;
    run(4);
    idle(); s_irq = 1; s_pc = 32'h0000_0300;
    run(5);
    check("pend_irq_mcause", env_mem[A_MCAUSE], 32'h8000_0007);
    check("pend_irq_mepc", env_mem[A_MEPC], 32'h0000_0300);
    idle();
    step();

    // Reset during T_CAUSE
    ms_snap = env_mem[A_MSTATUS];
    jc_snap = jump_cnt;
    s_valid = 1; s_ecall = 1; s_pc = 32'h0000_0400;
    run(2);
    s_rst = 1;
    step();
    idle();
    step();
    check("abort_hold", hold, 0);
    check("abort_jump_en", jump_en, 0);
    run(3);
    check("abort_no_mstatus_wr", env_mem[A_MSTATUS], ms_snap);
    check("abort_mcause_kept", env_mem[A_MCAUSE], 32'd11);
    check("abort_no_jump", jump_cnt, jc_snap);

    // Randomized traffic
    idle();
    for (int i = 0; i < 3000; i++) begin
      s_rst    = ($urandom_range(0, 99) == 0);
      s_valid  = 1'($urandom);
      s_ecall  = ($urandom_range(0, 15) == 0);
      s_ebreak = ($urandom_range(0, 15) == 0);
      s_mret   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) s_irq = ~s_irq;
      s_pc     = $urandom & 32'hFFFF_FFFC;
      s_wren   = 1'($urandom);
      s_wraddr = pick_addr();
      s_rdaddr = pick_addr();
      s_wrdata = $urandom;
      step();
    end
    idle();
    run(6);

    check("end_mstatus", env_mem[A_MSTATUS], mdl_csr[A_MSTATUS]);
    check("end_mtvec", env_mem[A_MTVEC], mdl_csr[A_MTVEC]);
    check("end_mepc", env_mem[A_MEPC], mdl_csr[A_MEPC]);
    check("end_mcause", env_mem[A_MCAUSE], mdl_csr[A_MCAUSE]);
    check("end_mscratch", env_mem[A_MSCRATCH], mdl_csr[A_MSCRATCH]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer that drives the single read/write port of the CSR register file. It is the master side of that port. It takes exceptions (ecall, ebreak) and the timer interrupt, and it executes mret. It performs the required CSR reads and writes one per cycle, stalls the pipeline, and redirects the PC. When idle, it passes the EX-stage CSR instruction traffic through to the CSR file unchanged.

## Interface
- Parameters:
- `MCAUSE_ECALL`, 32'd11, cause written for ecall
- `MCAUSE_EBREAK`, 32'd3, cause written for ebreak
- `MCAUSE_TIMER`, 32'h8000_0007, cause written for timer interrupt
- Ports:
- `clk`  in  1  single clock, all state on posedge
- `rst`  in  1  synchronous, active-high reset
- `ex_pc`  in  32  PC of instruction in EX
- `ex_ecall` / `ex_ebreak` / `ex_mret`  in  1 each  decoded EX instruction flags, valid only when `ex_valid`=1
- `ex_valid`  in  1  EX holds a live instruction
- `irq_timer`  in  1  level timer interrupt request
- `glb_int_en`  in  1  mstatus.MIE from the CSR file
- `ex_csr_rdaddr`, `ex_csr_wraddr`  in  12  pipeline CSR addresses
- `ex_csr_wren`  in  1  pipeline CSR write enable
- `ex_csr_wrdata`  in  32  pipeline CSR write data
- `csr_rdaddr`  out  12  to CSR file read address (combinational)
- `csr_rddata`  in  32  from CSR file; registered, valid the cycle after `csr_rdaddr`; read-during-write returns the write data
- `csr_wren`  out  1  to CSR file write enable (combinational)
- `csr_wraddr`  out  12  to CSR file write address (combinational)
- `csr_wrdata`  out  32  to CSR file write data (combinational)
- `hold`  out  1  stall IF/ID/EX
- `jump_en`  out  1  one-cycle PC redirect
- `jump_addr`  out  32  redirect target

## Operation
- CSR addresses come from the shared `CSRs_ADDR_*` defines: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342.
- Event selection in IDLE uses fixed priority:
  - ecall, then ebreak, then mret: each requires `ex_valid`.
  - Timer interrupt is lowest: requires `irq_timer && glb_int_en`.
- `accept` = any event selected while in IDLE.
- Pass-through: in IDLE with `accept`=0, the `csr_*` outputs equal the `ex_csr_*` inputs. In any other state, or when `accept`=1, the pipeline write is suppressed. An interrupted CSR instruction is squashed and re-executed after mret.
- On `accept`, the block latches:
  - `epc_q`=ex_pc
  - `cause_q`=the selected cause
- FSM states, one cycle each unless noted:
  - IDLE: on trap accept, `csr_rdaddr`=MSTATUS, then go to T_EPC. On mret accept, `csr_rdaddr`=MSTATUS, then go to R_EPC.
  - T_EPC: write MEPC←`epc_q`. `csr_rdaddr`=MTVEC. Capture `mstatus_q`←`csr_rddata`.
  - T_CAUSE: write MCAUSE←`cause_q`. Capture `mtvec_q`←`csr_rddata`.
  - T_STAT: write MSTATUS←`mstatus_q` with bit7 (MPIE)=`mstatus_q[3]` and bit3 (MIE)=0.
  - T_JUMP: `jump_en`=1, `jump_addr`={`mtvec_q[31:2]`,2'b00} (direct mode). Go to IDLE.
  - R_EPC: `csr_rdaddr`=MEPC. Capture `mstatus_q`.
  - R_STAT: write MSTATUS←`mstatus_q` with bit3=`mstatus_q[7]` and bit7=1. Capture `mepc_q`←`csr_rddata`.
  - R_JUMP: `jump_en`=1, `jump_addr`=`mepc_q`. Go to IDLE.
- `hold` = `accept` OR (state≠IDLE). It deasserts the cycle after the JUMP state.
- Outside the states listed above, `csr_wren`=0 and `csr_rdaddr`=0 (read data ignored).
- All other mstatus bits are written back unchanged.

## Timing
- Reset (`rst`=1 at posedge) does the following; the block is then idle, and `hold`, `csr_wren` and `csr_rdaddr` follow the IDLE/pass-through rules:
  - state←IDLE
  - `epc_q`, `cause_q`, `mstatus_q`, `mtvec_q`, `mepc_q` ←0
  - `jump_en`=0, `jump_addr`=0
- Reset mid-sequence aborts with no further CSR writes and no jump. CSR writes already issued are not undone.
- Trap latency: accept cycle N, then writes at N+1, N+2, N+3, then `jump_en` at N+4. `hold`=1 for N..N+4.
- mret latency: accept cycle N, one MSTATUS write at N+2, `jump_en` at N+3. `hold`=1 for N..N+3.
- Events arriving while not IDLE are ignored. The pipeline is held, so the EX flags remain stable.
- `irq_timer` is level-sensitive. After entry MIE=0, so the same level does not re-trap until mret restores MIE.
- mret with MPIE=1 and `irq_timer` still high: a new trap is accepted in the first IDLE cycle after R_JUMP that sees `glb_int_en`=1.
- `jump_en` is high for exactly one cycle per event.

## Test plan
- Reset, then idle: drive `ex_csr_wren`=1 with wraddr 0x340 and data 0xA5A5_0001 → `csr_wren`=1, `csr_wraddr`=0x340 and `csr_wrdata`=0xA5A5_0001 in the same cycle; `hold`=0.
- ecall at `ex_pc`=0x0000_0100 with mtvec=0x0000_0203 and mstatus=0x0000_0008 → writes MEPC=0x100, then MCAUSE=11, then MSTATUS=0x0000_0080; `jump_addr`=0x0000_0200 on cycle N+4; `hold` high for 5 cycles.
- mret following that trap → MSTATUS written 0x0000_0088 at N+2; `jump_en`, `jump_addr`=0x0000_0100 at N+3.
- Timer: `irq_timer`=1, `glb_int_en`=1, EX holds a csrw → pipeline write suppressed, MCAUSE=0x8000_0007. With `glb_int_en`=0 → no accept, `hold`=0.
- Simultaneous ecall and `irq_timer` → MCAUSE=11; the interrupt is taken after mret once MIE=1.
- `rst` asserted at T_CAUSE → no MSTATUS write, no `jump_en`; next cycle `hold`=0 and state is IDLE.
